// File: rtl/image_pkg.sv
// Shared types and constants for the frame buffer read path.
// Pixels are 12-bit 4:4:4 RGB; the source image is 320x240 and is shown at 640x480.
package image_pkg;

    localparam int PIX_W    = 12;
    localparam int ADDR_W   = 17;
    localparam int SRC_COLS = 320;
    localparam int SRC_ROWS = 240;
    localparam int DST_COLS = 640;
    localparam int DST_ROWS = 480;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t pixel;
        logic   sof;
        logic   eol;
        logic   eof;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } rd_state_t;

    // Colour bars, 128 output pixels wide, indexed by fx >> 7.
    function automatic pixel_t bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    bar_color = 12'hFFF;
            3'd1:    bar_color = 12'hFF0;
            3'd2:    bar_color = 12'h0FF;
            3'd3:    bar_color = 12'h0F0;
            3'd4:    bar_color = 12'hF0F;
            default: bar_color = 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of pixels with their frame flags, absorbing the one-cycle RAM read
// latency so the output can stall without losing fetched data.
module pixel_skid_fifo
    import image_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // NOTE: the two entries are reset as well, because the head drives out_pixel and
    // the flags directly and those must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_reader.sv
// Reads the 320x240 frame buffer and streams it pixel- and line-doubled as 640x480
// over valid/ready. Define TEST_PATTERN_EN to add a tp_en input selecting colour bars.
module frame_reader
    import image_pkg::*;
#(
    parameter int SRC_COLS = image_pkg::SRC_COLS,
    parameter int SRC_ROWS = image_pkg::SRC_ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic              abort,
`ifdef TEST_PATTERN_EN
    input  logic              tp_en,
`endif
    output logic              rden,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [PIX_W-1:0]  rddata,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy
);

    localparam int FX_W = $clog2(2 * SRC_COLS);
    localparam int FY_W = $clog2(2 * SRC_ROWS);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [FX_W-1:0]   fx_q;
    logic [FY_W-1:0]   fy_q;
    logic [ADDR_W-1:0] row_base_q;

    logic              inflight_q;
    logic              sof_q;
    logic              eol_q;
    logic              eof_q;
`ifdef TEST_PATTERN_EN
    logic              tp_sel_q;
    pixel_t            tp_pix_q;
`endif

    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              push;
    logic              fetch;
    logic              at_sof;
    logic              at_eol;
    logic              at_last_row;

    assign at_sof      = (fx_q == '0) && (fy_q == '0);
    assign at_eol      = (fx_q == FX_W'(2 * SRC_COLS - 1));
    assign at_last_row = (fy_q == FY_W'(2 * SRC_ROWS - 1));

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Occupancy is taken net of the beat leaving this cycle, which keeps two reads
    // in the pipe and sustains one pixel per clock when the sink never stalls.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch     = (state_q == STREAM) && (occupancy < 3'd2);

    assign rden      = fetch;
    assign rdaddress = row_base_q + ADDR_W'(fx_q >> 1);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!abort && frame_valid) state_d = STREAM;
            end
            STREAM: begin
                if (abort)                                  state_d = IDLE;
                else if (fetch && at_eol && at_last_row)    state_d = DRAIN;
            end
            DRAIN: begin
                if (abort)                                  state_d = IDLE;
                else if (fifo_count == 2'd0 && !inflight_q) state_d = frame_valid ? STREAM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walk: each source pixel is fetched twice along x, each source row twice along y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fx_q       <= '0;
            fy_q       <= '0;
            row_base_q <= '0;
        end else if (abort || state_q != STREAM) begin
            fx_q       <= '0;
            fy_q       <= '0;
            row_base_q <= '0;
        end else if (fetch) begin
            if (at_eol) begin
                fx_q <= '0;
                if (at_last_row) begin
                    fy_q       <= '0;
                    row_base_q <= '0;
                end else begin
                    fy_q <= fy_q + 1'b1;
                    if (fy_q[0]) row_base_q <= row_base_q + ADDR_W'(SRC_COLS);
                end
            end else begin
                fx_q <= fx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
`ifdef TEST_PATTERN_EN
            tp_sel_q   <= 1'b0;
            tp_pix_q   <= '0;
`endif
        end else begin
            inflight_q <= fetch && !abort;
            if (fetch) begin
                sof_q    <= at_sof;
                eol_q    <= at_eol;
                eof_q    <= at_eol && at_last_row;
`ifdef TEST_PATTERN_EN
                tp_sel_q <= tp_en;
                tp_pix_q <= bar_color(3'(fx_q >> 7));
`endif
            end
        end
    end

    always_comb begin
        wr_entry.pixel = rddata;
`ifdef TEST_PATTERN_EN
        if (tp_sel_q) wr_entry.pixel = tp_pix_q;
`endif
        wr_entry.sof   = sof_q;
        wr_entry.eol   = eol_q;
        wr_entry.eof   = eof_q;
    end

    // A read returning in the abort cycle belongs to the dropped frame.
    assign push = inflight_q && !abort;

    pixel_skid_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    assign out_pixel = head.pixel;
    assign out_sof   = head.sof;
    assign out_eol   = head.eol;
    assign out_eof   = head.eof;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_reader.sv
// Randomised self-checking bench for frame_reader, run on a 640x8 output frame so whole
// frames fit a short run; the expected stream is derived from (x, y) arithmetic.
module tb_frame_reader;

    localparam int COLS  = 320;
    localparam int ROWS  = 4;
    localparam int XW    = 2 * COLS;
    localparam int YH    = 2 * ROWS;
    localparam int FRAME = XW * YH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid;
    logic        abort;
`ifdef TEST_PATTERN_EN
    logic        tp_en;
`endif
    logic        rden;
    logic [16:0] rdaddress;
    logic [11:0] rddata;
    logic [11:0] out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    int   ready_mode = 0;
    logic tp_on = 1'b0;
    int   exp_n = 0;
    int   f_n = 0;
    int   n_xfer = 0;
    int   eof_cnt = 0;
    int   cyc = 0;
    int   sof_cyc = 0;
    int   eof_cyc = 0;
    logic prev_stall = 1'b0;
    logic [14:0] prev_beat = '0;
    logic [14:0] beat;

    assign beat = {out_pixel, out_sof, out_eol, out_eof};

    frame_reader #(.SRC_COLS(COLS), .SRC_ROWS(ROWS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .abort       (abort),
`ifdef TEST_PATTERN_EN
        .tp_en       (tp_en),
`endif
        .rden        (rden),
        .rdaddress   (rdaddress),
        .rddata      (rddata),
        .out_pixel   (out_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_addr(input int n);
        int x = n % XW;
        int y = n / XW;
        return (y / 2) * COLS + x / 2;
    endfunction

    function automatic logic [11:0] model_bar(input int b);
        case (b)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            default: return 12'hF0F;
        endcase
    endfunction

    function automatic logic [14:0] model_beat(input int n);
        logic [31:0] a;
        logic [11:0] p;
        int x = n % XW;
        a = model_addr(n);
        p = tp_on ? model_bar(x / 128) : a[11:0];
        return {p, n == 0, x == XW - 1, n == FRAME - 1};
    endfunction

    // RAM model: data for the address read in one cycle appears the next.
    initial begin
        logic        ram_en;
        logic [16:0] ram_a;
        forever begin
            @(negedge clk);
            ram_en = rden;
            ram_a  = rdaddress;
            @(posedge clk);
            #1;
            rddata = ram_en ? ram_a[11:0] : 12'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted beat and every fetch address against the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'(beat), 32'(prev_beat));
            end
            if (out_valid && out_ready) begin
                check("beat", 32'(beat), 32'(model_beat(exp_n)));
                if (exp_n == 0) sof_cyc = cyc;
                if (exp_n == FRAME - 1) begin
                    eof_cyc = cyc;
                    eof_cnt++;
                end
                exp_n = (exp_n + 1) % FRAME;
                n_xfer++;
            end
            if (rden) begin
                check("rdaddress", 32'(rdaddress), 32'(model_addr(f_n)));
                f_n = (f_n + 1) % FRAME;
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_beat  = beat;
        end
    end

    task automatic wait_xfers(input int target, input int budget);
        int c = 0;
        while (n_xfer < target && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (n_xfer < target) check("wait_xfers", 32'(n_xfer), 32'(target));
    endtask

    task automatic wait_eofs(input int target, input int budget);
        int c = 0;
        while (eof_cnt < target && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (eof_cnt < target) check("wait_eofs", 32'(eof_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            #2;
            c++;
        end
        if (busy) check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rden"}, 32'(rden), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int c;
        int base;
        int snap;
        int snap_e;
        rst_n       = 1'b0;
        frame_valid = 1'b0;
        abort       = 1'b0;
`ifdef TEST_PATTERN_EN
        tp_en       = 1'b0;
`endif
        out_ready   = 1'b1;
        rddata      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_beat", 32'(beat), 32'd0);
        check("reset_addr", 32'(rdaddress), 32'd0);

        // Frame A: sink always ready, latency and throughput
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        frame_valid = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (!busy && c < 10);
        check("start_busy", 32'(busy), 32'd1);
        check("start_rden", 32'(rden), 32'd1);
        check("start_addr", 32'(rdaddress), 32'd0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        wait_eofs(1, 3 * FRAME);
        check("throughput", 32'(eof_cyc - sof_cyc), 32'(FRAME - 1));

        // Frame B: back-to-back, random backpressure
        ready_mode = 1;
        wait_eofs(2, 4 * FRAME);
        ready_mode = 0;
        check("frames_ab", 32'(n_xfer), 32'(2 * FRAME));

        // Frame C: 10-clock stall mid-line, then frame_valid dropped at pixel 1000
        base = n_xfer;
        wait_xfers(base + 700, 3 * FRAME);
        ready_mode = 2;
        @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (i >= 2) check("stall_rden", 32'(rden), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        ready_mode = 0;
        wait_xfers(base + 1000, 3 * FRAME);
        frame_valid = 1'b0;
        wait_eofs(3, 3 * FRAME);
        wait_idle(20);
        repeat (20) @(negedge clk);
        #2;
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_count", 32'(n_xfer), 32'(3 * FRAME));

        // Frame D: abort at transfer 1000
        frame_valid = 1'b1;
        wait_xfers(3 * FRAME + 1000, 3 * FRAME);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_n = 0;
        f_n   = 0;
        @(negedge clk);
        #2;
        check_quiet("abort");

        // Restarted frame: asynchronous reset mid-line
        snap = n_xfer;
        wait_xfers(snap + 300, 3 * FRAME);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        check("midreset_beat", 32'(beat), 32'd0);
        check("midreset_addr", 32'(rdaddress), 32'd0);
        exp_n = 0;
        f_n   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap   = n_xfer;
        snap_e = eof_cnt;
        wait_xfers(snap + 100, 3 * FRAME);
        frame_valid = 1'b0;
        wait_eofs(snap_e + 1, 3 * FRAME);
        wait_idle(20);
        check("reset_frame_len", 32'(n_xfer - snap), 32'(FRAME));

`ifdef TEST_PATTERN_EN
        // Colour bars, random backpressure
        tp_en       = 1'b1;
        tp_on       = 1'b1;
        ready_mode  = 1;
        snap_e      = eof_cnt;
        frame_valid = 1'b1;
        wait_xfers(n_xfer + 50, 3 * FRAME);
        frame_valid = 1'b0;
        wait_eofs(snap_e + 1, 4 * FRAME);
        wait_idle(20);
        check("tp_idle", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
